// File: rtl/download_ctrl.sv
// download_ctrl: routes ioctl byte downloads to the game core (ROM image,
// game-select byte, DIP switch bytes) and sequences the core reset around
// ROM loads, game changes and user reset requests.
module download_ctrl #(
    parameter logic [7:0]  ROM_INDEX = 8'd0,
    parameter logic [7:0]  MOD_INDEX = 8'd1,
    parameter logic [7:0]  DIP_INDEX = 8'd254,
    parameter int unsigned RST_HOLD  = 16
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    input  logic        user_reset,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic [7:0]  mod_sel,
    output logic [7:0]  sw0,
    output logic [7:0]  sw1,
    output logic [7:0]  sw2,
    output logic        core_reset,
    output logic        rom_loaded,
    output logic        err_ovf
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_RUN  = 2'd3;

    // Counter runs HOLD_INIT..0, so HOLD spans exactly RST_HOLD cycles.
    localparam logic [7:0] HOLD_INIT = 8'(RST_HOLD - 1);

    logic [1:0]  state;
    logic [7:0]  hold_cnt;

    logic        rom_start;
    logic        rom_wr;
    logic        rom_ovf;
    logic        mod_wr;
    logic        dip_wr;

    logic        vld_p1;
    logic [15:0] addr_p1;
    logic [7:0]  data_p1;

    // A ROM download is "active" whenever the download flag is up for the ROM target;
    // writes above 64 KiB do not fit the core's address space and are trapped.
    assign rom_start = ioctl_download & (ioctl_index == ROM_INDEX);
    assign rom_wr    = ioctl_wr & rom_start & (ioctl_addr[24:16] == 9'd0);
    assign rom_ovf   = ioctl_wr & rom_start & (ioctl_addr[24:16] != 9'd0);
    assign mod_wr    = ioctl_wr & (ioctl_index == MOD_INDEX) & (ioctl_addr == 25'd0);
    assign dip_wr    = ioctl_wr & (ioctl_index == DIP_INDEX) & (ioctl_addr[24:3] == 22'd0);

    // Reset sequencer: load, then hold the core in reset, then release it.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            hold_cnt   <= 8'd0;
            rom_loaded <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rom_start) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (!ioctl_download) begin
                        state      <= ST_HOLD;
                        hold_cnt   <= HOLD_INIT;
                        rom_loaded <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (rom_start) begin
                        state <= ST_LOAD;
                    end else if (user_reset) begin
                        hold_cnt <= HOLD_INIT;
                    end else if (hold_cnt == 8'd0) begin
                        state <= ST_RUN;
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end
                ST_RUN: begin
                    if (rom_start) begin
                        state <= ST_LOAD;
                    end else if (user_reset || mod_wr) begin
                        state    <= ST_HOLD;
                        hold_cnt <= HOLD_INIT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign core_reset = (state != ST_RUN);

    // Stage p0 -> p1: register the ROM write bus toward the core.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            vld_p1  <= 1'b0;
            addr_p1 <= 16'd0;
            data_p1 <= 8'd0;
        end else begin
            vld_p1  <= rom_wr;
            addr_p1 <= ioctl_addr[15:0];
            data_p1 <= ioctl_dout;
        end
    end

    assign dn_wr   = vld_p1;
    assign dn_addr = addr_p1;
    assign dn_data = data_p1;

    // Sticky overflow flag for ROM writes outside the 16-bit window.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            err_ovf <= 1'b0;
        end else if (rom_ovf) begin
            err_ovf <= 1'b1;
        end
    end

    // Game-select and DIP bytes are captured in any state; DIP slots 3..7 are discarded.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            mod_sel <= 8'h00;
            sw0     <= 8'hFF;
            sw1     <= 8'hFF;
            sw2     <= 8'hFF;
        end else begin
            if (mod_wr) mod_sel <= ioctl_dout;
            if (dip_wr) begin
                case (ioctl_addr[2:0])
                    3'd0:    sw0 <= ioctl_dout;
                    3'd1:    sw1 <= ioctl_dout;
                    3'd2:    sw2 <= ioctl_dout;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_download_ctrl.sv
// tb_download_ctrl: directed scenarios plus randomized ioctl traffic, checked
// every cycle against a behavioural model of the download/reset rules.
module tb_download_ctrl;

    localparam logic [7:0] ROM_IDX = 8'd0;
    localparam logic [7:0] MOD_IDX = 8'd1;
    localparam logic [7:0] DIP_IDX = 8'd254;
    localparam int         HOLD    = 16;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_index;
    logic        user_reset;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic [7:0]  mod_sel;
    logic [7:0]  sw0;
    logic [7:0]  sw1;
    logic [7:0]  sw2;
    logic        core_reset;
    logic        rom_loaded;
    logic        err_ovf;

    always #5 clk_sys = ~clk_sys;

    download_ctrl #(
        .ROM_INDEX (ROM_IDX),
        .MOD_INDEX (MOD_IDX),
        .DIP_INDEX (DIP_IDX),
        .RST_HOLD  (HOLD)
    ) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .user_reset     (user_reset),
        .dn_addr        (dn_addr),
        .dn_data        (dn_data),
        .dn_wr          (dn_wr),
        .mod_sel        (mod_sel),
        .sw0            (sw0),
        .sw1            (sw1),
        .sw2            (sw2),
        .core_reset     (core_reset),
        .rom_loaded     (rom_loaded),
        .err_ovf        (err_ovf)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behavioural model: the core is in reset while idle, while loading, or while
    // reset cycles remain to be served (hold_left counts those cycles down).
    bit          m_idle;
    bit          m_loading;
    int          m_hold_left;
    bit          m_loaded;
    bit          m_ovf;
    logic [7:0]  m_mod;
    logic [7:0]  m_sw [3];
    bit          m_dn_wr;
    logic [15:0] m_dn_addr;
    logic [7:0]  m_dn_data;

    task automatic model_step();
        bit rstart;
        bit modw;
        if (!reset_n) begin
            m_idle = 1; m_loading = 0; m_hold_left = 0; m_loaded = 0; m_ovf = 0;
            m_mod = 8'h00; m_sw[0] = 8'hFF; m_sw[1] = 8'hFF; m_sw[2] = 8'hFF;
            m_dn_wr = 0; m_dn_addr = 16'h0; m_dn_data = 8'h0;
        end else begin
            rstart    = ioctl_download && (ioctl_index == ROM_IDX);
            m_dn_wr   = ioctl_wr && rstart && (ioctl_addr < 25'h10000);
            m_dn_addr = ioctl_addr[15:0];
            m_dn_data = ioctl_dout;
            if (ioctl_wr && rstart && (ioctl_addr >= 25'h10000)) m_ovf = 1;
            modw = ioctl_wr && (ioctl_index == MOD_IDX) && (ioctl_addr == 25'd0);
            if (modw) m_mod = ioctl_dout;
            if (ioctl_wr && (ioctl_index == DIP_IDX) && (ioctl_addr < 25'd3))
                m_sw[int'(ioctl_addr[1:0])] = ioctl_dout;

            if (rstart && !m_loading) begin
                m_loading = 1; m_idle = 0; m_hold_left = 0;
            end else if (m_loading) begin
                if (!ioctl_download) begin
                    m_loading = 0; m_hold_left = HOLD; m_loaded = 1;
                end
            end else if (m_idle) begin
                m_idle = 1;
            end else if (m_hold_left > 0) begin
                if (user_reset) m_hold_left = HOLD;
                else            m_hold_left = m_hold_left - 1;
            end else if (user_reset || modw) begin
                m_hold_left = HOLD;
            end
        end
    endtask

    task automatic compare_all();
        check("core_reset", core_reset, 32'(m_idle || m_loading || (m_hold_left > 0)));
        check("dn_wr", dn_wr, 32'(m_dn_wr));
        if (m_dn_wr) begin
            check("dn_addr", dn_addr, 32'(m_dn_addr));
            check("dn_data", dn_data, 32'(m_dn_data));
        end
        check("mod_sel", mod_sel, 32'(m_mod));
        check("sw0", sw0, 32'(m_sw[0]));
        check("sw1", sw1, 32'(m_sw[1]));
        check("sw2", sw2, 32'(m_sw[2]));
        check("rom_loaded", rom_loaded, 32'(m_loaded));
        check("err_ovf", err_ovf, 32'(m_ovf));
    endtask

    task automatic tick();
        @(posedge clk_sys);
        model_step();
        @(negedge clk_sys);
        compare_all();
    endtask

    task automatic wbyte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
        ioctl_index = idx;
        ioctl_addr  = a;
        ioctl_dout  = d;
        ioctl_wr    = 1'b1;
        tick();
        ioctl_wr    = 1'b0;
    endtask

    // Counts consecutive sampled cycles with core_reset high; optionally pulses
    // user_reset during the pulse_at-th such cycle.
    task automatic measure_reset(input int pulse_at, output int len);
        len = 0;
        while (core_reset === 1'b1 && len < 60) begin
            len++;
            user_reset = (len == pulse_at);
            tick();
            user_reset = 1'b0;
        end
    endtask

    initial begin
        int len;
        bit dl;
        reset_n = 0; ioctl_download = 0; ioctl_wr = 0; ioctl_addr = '0;
        ioctl_dout = '0; ioctl_index = '0; user_reset = 0;
        tick();
        tick();
        check("rst_core_reset", core_reset, 1);
        check("rst_rom_loaded", rom_loaded, 0);
        check("rst_sw0", sw0, 8'hFF);
        check("rst_mod_sel", mod_sel, 8'h00);
        check("rst_dn_wr", dn_wr, 0);
        reset_n = 1;
        tick();

        // ROM download of four bytes, then release
        ioctl_download = 1; ioctl_index = ROM_IDX;
        tick();
        for (int i = 0; i < 4; i++) begin
            wbyte(ROM_IDX, 25'(i), 8'(8'hA0 + i));
            check("rom_dn_wr", dn_wr, 1);
            check("rom_dn_addr", dn_addr, 32'(i));
            check("rom_dn_data", dn_data, 32'(8'hA0 + i));
            check("rom_core_reset", core_reset, 1);
            tick();
            check("rom_dn_wr_gap", dn_wr, 0);
        end
        ioctl_download = 0;
        tick();
        measure_reset(0, len);
        check("rom_hold_len", len, 16);
        check("rom_loaded_after", rom_loaded, 1);

        // DIP bytes while running
        ioctl_download = 1;
        wbyte(DIP_IDX, 25'd0, 8'h12); check("dip_sw0_next", sw0, 8'h12);
        wbyte(DIP_IDX, 25'd1, 8'h34);
        wbyte(DIP_IDX, 25'd2, 8'h56);
        wbyte(DIP_IDX, 25'd5, 8'h78);
        check("dip_no_dn_wr", dn_wr, 0);
        ioctl_download = 0;
        tick();
        check("dip_sw0", sw0, 8'h12);
        check("dip_sw1", sw1, 8'h34);
        check("dip_sw2", sw2, 8'h56);
        check("dip_core_reset", core_reset, 0);

        // Game select, plain and stretched by user_reset
        wbyte(MOD_IDX, 25'd0, 8'h0B);
        check("mod_sel_val", mod_sel, 8'h0B);
        measure_reset(0, len);
        check("mod_hold_len", len, 16);
        wbyte(MOD_IDX, 25'd0, 8'h0B);
        measure_reset(10, len);
        check("mod_stretch_len", len, 26);

        // Out-of-window ROM write
        ioctl_download = 1; ioctl_index = ROM_IDX;
        tick();
        wbyte(ROM_IDX, 25'h10000, 8'h5A);
        check("ovf_dn_wr", dn_wr, 0);
        check("ovf_flag", err_ovf, 1);
        wbyte(ROM_IDX, 25'h00000, 8'hC3);
        check("ovf_next_dn_wr", dn_wr, 1);
        check("ovf_next_dn_data", dn_data, 8'hC3);
        ioctl_download = 0;
        tick();
        measure_reset(0, len);
        check("ovf_sticky", err_ovf, 1);

        // Reset in the middle of a load with download still asserted
        ioctl_download = 1; ioctl_index = ROM_IDX;
        tick();
        wbyte(ROM_IDX, 25'd1, 8'h11);
        reset_n = 0;
        tick();
        check("midrst_rom_loaded", rom_loaded, 0);
        check("midrst_sw0", sw0, 8'hFF);
        check("midrst_err_ovf", err_ovf, 0);
        check("midrst_core_reset", core_reset, 1);
        reset_n = 1;
        tick();
        wbyte(ROM_IDX, 25'd2, 8'h22);
        check("midrst_dn_wr", dn_wr, 1);
        check("midrst_dn_addr", dn_addr, 16'd2);
        ioctl_download = 0;
        tick();
        measure_reset(0, len);
        check("midrst_hold_len", len, 16);
        check("midrst_loaded", rom_loaded, 1);

        // Randomized traffic
        dl = 0;
        for (int c = 0; c < 3000; c++) begin
            int r;
            if ($urandom_range(0, 39) == 0) dl = !dl;
            ioctl_download = dl;
            r = int'($urandom_range(0, 9));
            if (dl && r < 7)  ioctl_index = ROM_IDX;
            else if (r < 3)   ioctl_index = MOD_IDX;
            else if (r < 8)   ioctl_index = DIP_IDX;
            else              ioctl_index = 8'($urandom_range(0, 255));
            ioctl_wr = ($urandom_range(0, 2) == 0);
            r = int'($urandom_range(0, 9));
            if (r < 6)       ioctl_addr = 25'($urandom_range(0, 7));
            else if (r < 8)  ioctl_addr = 25'($urandom_range(0, 16'hFFFF));
            else if (r == 8) ioctl_addr = 25'($urandom);
            else             ioctl_addr = 25'd0;
            ioctl_dout = 8'($urandom_range(0, 255));
            user_reset = ($urandom_range(0, 29) == 0);
            reset_n    = !($urandom_range(0, 299) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/download_ctrl.md
DOWNLOAD_CTRL -- requirements
Module: download_ctrl

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- ROM_INDEX, 0, ioctl_index value for ROM image.
- MOD_INDEX, 1, ioctl_index value for game-select byte.
- DIP_INDEX, 254, ioctl_index value for DIP bytes.
- RST_HOLD, 16, RUN-entry delay in clk_sys cycles, legal range 1..255.

REQ-002 Ports, one per line (name, direction, width, meaning), clock and reset first:
- clk_sys, in, 1, sole clock.
- reset_n, in, 1, synchronous active-low reset.
- ioctl_download, in, 1, download in progress.
- ioctl_wr, in, 1, byte strobe.
- ioctl_addr, in, 25, byte address.
- ioctl_dout, in, 8, byte data.
- ioctl_index, in, 8, download target.
- user_reset, in, 1, menu/button reset request, active-high.
- dn_addr, out, 16, ROM write address to core.
- dn_data, out, 8, ROM write data.
- dn_wr, out, 1, ROM write strobe.
- mod_sel, out, 8, latched game-select byte.
- sw0, out, 8, DIP byte 0.
- sw1, out, 8, DIP byte 1.
- sw2, out, 8, DIP byte 2.
- core_reset, out, 1, active-high reset to game core.
- rom_loaded, out, 1, at least one ROM download has completed.
- err_ovf, out, 1, sticky flag: ROM write with ioctl_addr[24:16] != 0.

Function
REQ-003 The block SHALL use a four-state FSM: IDLE, LOAD, HOLD, RUN.
REQ-004 IDLE SHALL go to LOAD when ioctl_download=1 and ioctl_index=ROM_INDEX.
REQ-005 LOAD SHALL go to HOLD on the first cycle ioctl_download=0, load the hold counter with RST_HOLD-1, and set rom_loaded=1.
REQ-006 HOLD SHALL decrement the counter each cycle and go to RUN on the cycle after the counter reaches 0, so HOLD lasts exactly RST_HOLD cycles.
REQ-007 RUN SHALL go to LOAD on a ROM download start (as REQ-004).
REQ-008 RUN SHALL go to HOLD, reloading the counter, when user_reset=1 or when a MOD_INDEX byte is written; ROM start takes priority over both.
REQ-009 In HOLD, user_reset=1 SHALL reload the counter (stretch); ROM download start SHALL go to LOAD.
REQ-010 In LOAD and IDLE, user_reset SHALL be ignored.
REQ-011 core_reset SHALL equal (state != RUN), decoded directly from the state register.
REQ-012 dn_addr, dn_data and dn_wr SHALL be registered with one cycle of latency.
REQ-013 dn_wr SHALL be 1 only for a byte where ioctl_wr=1, ioctl_download=1, ioctl_index=ROM_INDEX and ioctl_addr[24:16]=0.
REQ-014 dn_addr SHALL be ioctl_addr[15:0] and dn_data SHALL be ioctl_dout.
REQ-015 A ROM write with ioctl_addr[24:16] != 0 SHALL be suppressed (dn_wr=0) and SHALL set err_ovf, which stays set until reset_n.
REQ-016 mod_sel SHALL capture ioctl_dout when ioctl_wr=1, ioctl_index=MOD_INDEX and ioctl_addr=0; writes at other addresses SHALL be ignored. The capture SHALL be valid in any state.
REQ-017 When ioctl_wr=1, ioctl_index=DIP_INDEX and ioctl_addr[24:3]=0:
- address 0, 1, 2 SHALL update sw0, sw1, sw2 respectively;
- addresses 3..7 SHALL be accepted and discarded.
REQ-018 DIP writes SHALL NOT change FSM state; a change to sw0..sw2 SHALL appear on the outputs on the cycle after the strobe.
REQ-019 A write strobe with any other ioctl_index SHALL have no effect.
REQ-020 ioctl_wr with ioctl_download=0 SHALL be ignored for ROM, and honoured for MOD and DIP.

Reset
REQ-021 While reset_n=0 at a clk_sys edge, the block SHALL set: state=IDLE, counter=0, dn_wr=0, dn_addr=0, dn_data=0, mod_sel=0, sw0=sw1=sw2=8'hFF, rom_loaded=0, err_ovf=0. core_reset is therefore 1.
REQ-022 Reset asserted mid-LOAD SHALL abandon the download. After release the block SHALL stay in IDLE until a new ROM download starts, even if ioctl_download is still 1 with index ROM; that case SHALL enter LOAD on the first cycle after release.

Verification
REQ-023 After reset, ROM download of 4 bytes (addr 0..3, data A0..A3) then drop ioctl_download -> dn_wr pulses 4 times, each 1 cycle after its ioctl_wr, with matching addr/data. core_reset=1 throughout, then exactly 16 more cycles of core_reset=1, then 0; rom_loaded=1.
REQ-024 In RUN, DIP download bytes 0x12 @0, 0x34 @1, 0x56 @2, 0x78 @5 -> sw0=12, sw1=34, sw2=56; core_reset stays 0; no dn_wr.
REQ-025 In RUN, MOD byte 0x0B @0 -> mod_sel=0B; core_reset=1 for 16 cycles. A user_reset pulse at HOLD cycle 10 extends core_reset to 26 cycles total.
REQ-026 ROM write at ioctl_addr=0x10000 -> dn_wr stays 0 and err_ovf=1; a subsequent valid write @0x0000 produces dn_wr.
REQ-027 reset_n=0 for 1 cycle during LOAD with ioctl_download held 1 -> state returns to IDLE, sw*=FF, rom_loaded=0, then LOAD on the next cycle; dn_wr resumes on the next ioctl_wr.
